pc_unit: RTL

//  Parametrised program-counter unit for the IF stage of the 5-stage pipeline.

---
 rtl/pc_unit_pkg.sv | 8 +
 rtl/pc_unit_if.sv | 28 ++
 rtl/pc_unit_next_sel.sv | 37 +++
 rtl/pc_unit.sv | 55 +++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_pkg: shared types and the alignment-mask helper for the program-counter unit.
package pc_pkg;
   typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_FAULT} pc_state_t;
   typedef enum logic [2:0] {SRC_SEQ, SRC_HOLD, SRC_BR, SRC_JAL, SRC_JALR} pc_src_t;
   function automatic logic [1:0] align_mask(input int ialign);
      return ialign == 16 ? 2'b01 : 2'b11;
   endfunction
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: redirect/stall controls into the PC unit and fetch/fault status out of it.
interface pc_unit_if #(
   parameter int XLEN      = 32,
   parameter int BR_OFF_W  = 13,
   parameter int JAL_OFF_W = 21
);
   logic                 stall;
   logic [XLEN-1:0]      redirect_base;
   logic                 branch;
   logic [BR_OFF_W-1:0]  branch_offset;
   logic                 jump;
   logic [JAL_OFF_W-1:0] jump_offset;
   logic                 jalr;
   logic [XLEN-1:0]      jalr_target;
   logic                 trap_ack;
   logic [XLEN-1:0]      pc;
   logic                 pc_valid;
   logic                 misalign;
   logic [XLEN-1:0]      fault_addr;
   modport master (
      output stall, redirect_base, branch, branch_offset, jump, jump_offset, jalr, jalr_target, trap_ack,
      input  pc, pc_valid, misalign, fault_addr
   );
   modport slave (
      input  stall, redirect_base, branch, branch_offset, jump, jump_offset, jalr, jalr_target, trap_ack,
      output pc, pc_valid, misalign, fault_addr
   );
endinterface

// File: rtl/pc_unit_next_sel.sv
// pc_next_sel: computes redirect targets, picks the next PC by priority and flags misaligned redirects.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BR_OFF_W  = 13,
   parameter int JAL_OFF_W = 21,
   parameter int IALIGN    = 32
) (
   input  logic [XLEN-1:0]      pc,
   input  logic                 stall,
   input  logic [XLEN-1:0]      redirect_base,
   input  logic                 branch,
   input  logic [BR_OFF_W-1:0]  branch_offset,
   input  logic                 jump,
   input  logic [JAL_OFF_W-1:0] jump_offset,
   input  logic                 jalr,
   input  logic [XLEN-1:0]      jalr_target,
   output logic [XLEN-1:0]      next_pc,
   output logic                 bad
);
   pc_src_t src;
   logic [XLEN-1:0] br_tgt, jal_tgt, jalr_tgt, inc;
   assign br_tgt   = redirect_base + {{(XLEN-BR_OFF_W){branch_offset[BR_OFF_W-1]}}, branch_offset};
   assign jal_tgt  = redirect_base + {{(XLEN-JAL_OFF_W){jump_offset[JAL_OFF_W-1]}}, jump_offset};
   assign jalr_tgt = {jalr_target[XLEN-1:1], 1'b0};
   assign inc      = XLEN'(IALIGN == 16 ? 2 : 4);
   always_comb begin
      src     = jalr ? SRC_JALR : jump ? SRC_JAL : branch ? SRC_BR : stall ? SRC_HOLD : SRC_SEQ;
      next_pc = src == SRC_JALR ? jalr_tgt :
                src == SRC_JAL  ? jal_tgt  :
                src == SRC_BR   ? br_tgt   :
                src == SRC_HOLD ? pc       : pc + inc;
   end
   // Only redirect targets can be misaligned; pc+inc and hold preserve alignment.
   assign bad = (src inside {SRC_BR, SRC_JAL, SRC_JALR}) && |(next_pc[1:0] & align_mask(IALIGN));
endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage fetch PC register with boot bubble, stall, redirects and misaligned-target fault.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              BR_OFF_W     = 13,
   parameter int              JAL_OFF_W    = 21,
   parameter int              IALIGN       = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 'h0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100
) (
   input logic     clk,
   input logic     rst,
   pc_unit_if.slave bus
);
   pc_state_t state;
   logic [XLEN-1:0] pc_q, fault_q, next_pc;
   logic bad;
   pc_next_sel #(.XLEN(XLEN), .BR_OFF_W(BR_OFF_W), .JAL_OFF_W(JAL_OFF_W), .IALIGN(IALIGN)) u_sel (
      .pc            (pc_q),
      .stall         (bus.stall),
      .redirect_base (bus.redirect_base),
      .branch        (bus.branch),
      .branch_offset (bus.branch_offset),
      .jump          (bus.jump),
      .jump_offset   (bus.jump_offset),
      .jalr          (bus.jalr),
      .jalr_target   (bus.jalr_target),
      .next_pc       (next_pc),
      .bad           (bad)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= PC_BOOT;
         pc_q    <= RESET_VECTOR;
         fault_q <= '0;
      end else if (state == PC_BOOT) begin
         state <= PC_RUN;
      end else if (state == PC_RUN) begin
         if (bad) begin
            state   <= PC_FAULT;
            fault_q <= next_pc;
         end else begin
            pc_q <= next_pc;
         end
      end else if (bus.trap_ack) begin
         state <= PC_RUN;
         pc_q  <= TRAP_VECTOR;
      end
   end
   assign bus.pc         = pc_q;
   assign bus.pc_valid   = state == PC_RUN;
   assign bus.misalign   = state == PC_FAULT;
   assign bus.fault_addr = fault_q;
endmodule
